// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types and constants for the memory-link controller.
//   state_e        controller FSM states
//   BEATS          bus beats per cache line at default widths
//   BEAT_CNT_W     width of the beat counter
//   TIMEOUT_DEF    default progress timeout in cycles
//   line_align()   clears the byte-within-line bits of an address
package mem_bus_pkg;

  localparam int BUS_BITS_DEF  = 32;
  localparam int BEATS         = 8;
  localparam int LINE_BITS_DEF = BEATS * BUS_BITS_DEF;
  localparam int BEAT_CNT_W    = $clog2(BEATS);
  localparam int TIMEOUT_DEF   = 1024;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_RD_ACK  = 3'd3,
    ST_WR_ADDR = 3'd4,
    ST_WR_DATA = 3'd5,
    ST_WR_WAIT = 3'd6,
    ST_ERR     = 3'd7
  } state_e;

  // The link always carries a 32-byte aligned line address.
  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFE0;
  endfunction

endpackage

// File: rtl/mem_bus_beat_buffer.sv
// mem_bus_beat_buffer: one cache line of storage viewed as BUS_BITS-wide beats.
// Used both to serialise a write line and to assemble a read line.
//   clk, rst_n   clock, async active-low reset (clears the line)
//   load_i       load the whole line from line_i (has priority over wr_en_i)
//   wr_en_i      write wr_beat_i into beat wr_idx_i
//   rd_idx_i     selects the beat driven on rd_beat_o
//   line_o       full registered line
module mem_bus_beat_buffer #(
  parameter int LINE_BITS = 256,
  parameter int BUS_BITS  = 32,
  parameter int IDX_W     = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic [LINE_BITS-1:0] line_i,
  input  logic                 wr_en_i,
  input  logic [IDX_W-1:0]     wr_idx_i,
  input  logic [BUS_BITS-1:0]  wr_beat_i,
  input  logic [IDX_W-1:0]     rd_idx_i,
  output logic [BUS_BITS-1:0]  rd_beat_o,
  output logic [LINE_BITS-1:0] line_o
);

  localparam int NB = LINE_BITS / BUS_BITS;

  logic [LINE_BITS-1:0] line_q, line_d;

  always_comb begin
    line_d = line_q;
    if (load_i) begin
      line_d = line_i;
    end else if (wr_en_i) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_idx_i == IDX_W'(b)) line_d[b*BUS_BITS +: BUS_BITS] = wr_beat_i;
      end
    end
  end

  always_comb begin
    rd_beat_o = '0;
    for (int b = 0; b < NB; b++) begin
      if (rd_idx_i == IDX_W'(b)) rd_beat_o = line_q[b*BUS_BITS +: BUS_BITS];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) line_q <= '0;
    else        line_q <= line_d;
  end

  assign line_o = line_q;

endmodule

// File: rtl/mem_bus_controller.sv
// mem_bus_controller: serialises one cache-line read or write at a time onto
// the narrow multiplexed memory link and reassembles read beats into a line.
//   req_*        request from cache/arbiter; req_ready high only in IDLE
//   rsp_*        one-cycle completion pulse, rsp_rdata valid for reads
//   err          sticky: memory made no progress for TIMEOUT cycles
//   *_c_to_m     registered link outputs towards memory
//   *_m_to_c     link inputs from memory
//   dbg_state    current FSM state (mem_bus_pkg::state_e encoding)
//
// Handshake: a request transfers on a clk edge where
// req_ready && (req_read || req_write); req_read wins when both are high and
// the write must be presented again. Request inputs are don't-care while
// req_ready is low. rsp_valid has no ready: the requester must take it.
module mem_bus_controller
  import mem_bus_pkg::*;
#(
  parameter int LINE_BITS = LINE_BITS_DEF,
  parameter int BUS_BITS  = BUS_BITS_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          req_addr,
  input  logic                 req_read,
  input  logic                 req_write,
  input  logic [LINE_BITS-1:0] req_wdata,
  output logic                 req_ready,
  output logic                 rsp_valid,
  output logic                 rsp_is_write,
  output logic [LINE_BITS-1:0] rsp_rdata,
  output logic                 err,
  output logic [BUS_BITS-1:0]  address_data_bus_c_to_m,
  output logic                 address_on_c_to_m,
  output logic                 data_on_c_to_m,
  output logic                 read_en_c_to_m,
  output logic                 write_en_c_to_m,
  output logic                 resp_c_to_m,
  input  logic [BUS_BITS-1:0]  address_data_bus_m_to_c,
  input  logic                 data_on_m_to_c,
  input  logic                 resp_m_to_c,
  output logic [2:0]           dbg_state
);

  localparam int NBEATS = LINE_BITS / BUS_BITS;
  localparam int CNT_W  = (NBEATS == BEATS) ? BEAT_CNT_W : $clog2(NBEATS);
  localparam int TW     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);
  localparam logic [TW-1:0]    TMO_LAST  = TW'(TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [TW-1:0]        tmo_q, tmo_d;

  logic [BUS_BITS-1:0]  bus_q, bus_d;
  logic                 addr_on_q, addr_on_d;
  logic                 data_on_q, data_on_d;
  logic                 rd_en_q, rd_en_d;
  logic                 wr_en_q, wr_en_d;
  logic                 resp_q, resp_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_is_write_q, rsp_is_write_d;

  logic                 acc_rd, acc_wr;
  logic                 beat_in;
  logic [CNT_W-1:0]     buf_rd_idx;
  logic [BUS_BITS-1:0]  buf_rd_beat;
  logic [LINE_BITS-1:0] buf_line;

  assign acc_rd  = (state_q == ST_IDLE) && req_read;
  assign acc_wr  = (state_q == ST_IDLE) && !req_read && req_write;
  assign beat_in = (state_q == ST_RD_DATA) && data_on_m_to_c;

  // Link outputs are registered from the next state, so the buffer must
  // already present the beat for the coming cycle: beat 0 while in WR_ADDR,
  // beat cnt+1 while in WR_DATA.
  assign buf_rd_idx = (state_q == ST_WR_DATA) ? cnt_q + CNT_W'(1) : '0;

  mem_bus_beat_buffer #(
    .LINE_BITS (LINE_BITS),
    .BUS_BITS  (BUS_BITS),
    .IDX_W     (CNT_W)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (acc_wr),
    .line_i    (req_wdata),
    .wr_en_i   (beat_in),
    .wr_idx_i  (cnt_q),
    .wr_beat_i (address_data_bus_m_to_c),
    .rd_idx_i  (buf_rd_idx),
    .rd_beat_o (buf_rd_beat),
    .line_o    (buf_line)
  );

  // State register (with beat and progress counters)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (acc_rd)      state_d = ST_RD_ADDR;
        else if (acc_wr) state_d = ST_WR_ADDR;
      end
      ST_RD_ADDR: state_d = ST_RD_DATA;
      ST_RD_DATA: begin
        if (data_on_m_to_c) begin
          if (cnt_q == LAST_BEAT) state_d = ST_RD_ACK;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_ERR;
        end
      end
      ST_RD_ACK:  state_d = ST_IDLE;
      ST_WR_ADDR: state_d = ST_WR_DATA;
      ST_WR_DATA: if (cnt_q == LAST_BEAT) state_d = ST_WR_WAIT;
      ST_WR_WAIT: begin
        if (resp_m_to_c)            state_d = ST_IDLE;
        else if (tmo_q == TMO_LAST) state_d = ST_ERR;
      end
      ST_ERR:     state_d = ST_ERR;
      default:    state_d = ST_IDLE;
    endcase

    // Beat counter only lives in the data states; it wraps to 0 on the
    // last beat, which is also the exit condition.
    cnt_d = '0;
    if (state_d == ST_RD_DATA || state_d == ST_WR_DATA || state_d == ST_RD_ACK) begin
      if (state_q == ST_WR_DATA || beat_in) cnt_d = cnt_q + CNT_W'(1);
      else                                  cnt_d = cnt_q;
    end

    // Progress counter: counts idle cycles while waiting on memory.
    tmo_d = '0;
    if ((state_q == ST_RD_DATA && !data_on_m_to_c) ||
        (state_q == ST_WR_WAIT && !resp_m_to_c)) begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  // Output logic (next values of the registered outputs)
  always_comb begin
    bus_d          = '0;
    addr_on_d      = 1'b0;
    data_on_d      = 1'b0;
    rd_en_d        = 1'b0;
    wr_en_d        = 1'b0;
    resp_d         = 1'b0;
    rsp_valid_d    = 1'b0;
    rsp_is_write_d = 1'b0;
    unique case (state_d)
      ST_RD_ADDR: begin
        addr_on_d = 1'b1;
        rd_en_d   = 1'b1;
        bus_d     = BUS_BITS'(line_align(req_addr));
      end
      ST_WR_ADDR: begin
        addr_on_d = 1'b1;
        wr_en_d   = 1'b1;
        bus_d     = BUS_BITS'(line_align(req_addr));
      end
      ST_WR_DATA: begin
        data_on_d = 1'b1;
        wr_en_d   = 1'b1;
        bus_d     = buf_rd_beat;
      end
      ST_RD_ACK: begin
        resp_d      = 1'b1;
        rsp_valid_d = 1'b1;
      end
      default: ;
    endcase
    // Write completion is reported in the cycle after the memory's resp.
    if (state_q == ST_WR_WAIT && resp_m_to_c) begin
      rsp_valid_d    = 1'b1;
      rsp_is_write_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_q          <= '0;
      addr_on_q      <= 1'b0;
      data_on_q      <= 1'b0;
      rd_en_q        <= 1'b0;
      wr_en_q        <= 1'b0;
      resp_q         <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_is_write_q <= 1'b0;
    end else begin
      bus_q          <= bus_d;
      addr_on_q      <= addr_on_d;
      data_on_q      <= data_on_d;
      rd_en_q        <= rd_en_d;
      wr_en_q        <= wr_en_d;
      resp_q         <= resp_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_is_write_q <= rsp_is_write_d;
    end
  end

  assign address_data_bus_c_to_m = bus_q;
  assign address_on_c_to_m       = addr_on_q;
  assign data_on_c_to_m          = data_on_q;
  assign read_en_c_to_m          = rd_en_q;
  assign write_en_c_to_m         = wr_en_q;
  assign resp_c_to_m             = resp_q;
  assign rsp_valid               = rsp_valid_q;
  assign rsp_is_write            = rsp_is_write_q;
  assign rsp_rdata               = (rsp_valid_q && !rsp_is_write_q) ? buf_line : '0;
  assign req_ready               = (state_q == ST_IDLE);
  assign err                     = (state_q == ST_ERR);
  assign dbg_state               = state_q;

endmodule
